// File: rtl/ex_result_buffer_pkg.sv
// Shared widths and status-flag packing for the execute/writeback boundary.
// Flag field per buffered entry is 4 bits: Z=0, V=1, C=2, N=3.
package ex_result_buffer_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned RD_W_DEF   = 5;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 3;

  typedef logic [FLAG_W-1:0] flags_t;

  function automatic flags_t pack_flags(input logic z, input logic v,
                                        input logic c, input logic n);
    flags_t f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/ex_fwd_match.sv
// Forwarding lookup: youngest valid write-enabled entry whose rd matches.
// Scans head (oldest) to tail-1 (youngest) so the last match wins.
module ex_fwd_match #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0]         wb_en,
  input  logic [RD_W-1:0]          rd     [DEPTH],
  input  logic [DATA_W-1:0]        result [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [RD_W-1:0]          fwd_rd,
  output logic                     hit_c,
  output logic [DATA_W-1:0]        data_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  always_comb begin
    hit_c  = 1'b0;
    data_c = '0;
    idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      // r0 is hardwired zero in the register file and is never forwarded
      if (valid[idx] && wb_en[idx] && (rd[idx] == fwd_rd) && (fwd_rd != '0)) begin
        hit_c  = 1'b1;
        data_c = result[idx];
      end
    end
  end

endmodule

// File: rtl/ex_result_buffer.sv
// In-order result FIFO between ALU and writeback; commits status flags on pop
// and exposes a forwarding lookup over buffered results.
module ex_result_buffer
  import ex_result_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_W   = RD_W_DEF,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_zero,
  input  logic                     in_overflow,
  input  logic                     in_carry,
  input  logic                     in_negative,
  input  logic [RD_W-1:0]          in_rd,
  input  logic                     in_wb_en,
  input  logic                     in_set_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic [RD_W-1:0]          out_rd,
  output logic                     out_wb_en,
  output logic                     flag_z,
  output logic                     flag_v,
  output logic                     flag_c,
  output logic                     flag_n,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [RD_W-1:0]          fwd_rd,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [DATA_W-1:0] result_mem [DEPTH];
  logic [RD_W-1:0]   rd_mem     [DEPTH];
  flags_t            flags_mem  [DEPTH];
  logic [DEPTH-1:0]  wb_mem;
  logic [DEPTH-1:0]  setf_mem;
  flags_t            flags_q;
  logic              push;
  logic              pop;
  logic [DEPTH-1:0]  slot_valid;
  logic [PTR_W-1:0]  off;

  // Handshake derived from registered occupancy only
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_result = result_mem[head];
  assign out_rd     = rd_mem[head];
  assign out_wb_en  = wb_mem[head];

  assign flag_z = flags_q[FLAG_Z];
  assign flag_v = flags_q[FLAG_V];
  assign flag_c = flags_q[FLAG_C];
  assign flag_n = flags_q[FLAG_N];

  // Pointers, occupancy and committed flags; flush wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      flags_q <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop) begin
        head <= head + PTR_W'(1);
        if (setf_mem[head]) flags_q <= flags_mem[head];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; validity comes from count
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      result_mem[tail] <= in_result;
      rd_mem[tail]     <= in_rd;
      wb_mem[tail]     <= in_wb_en;
      setf_mem[tail]   <= in_set_flags;
      flags_mem[tail]  <= pack_flags(in_zero, in_overflow, in_carry, in_negative);
    end
  end

  // A slot is live if its distance from head is below occupancy
  always_comb begin
    slot_valid = '0;
    off        = '0;
    for (int unsigned s = 0; s < DEPTH; s++) begin
      off           = PTR_W'(s) - head;
      slot_valid[s] = ({1'b0, off} < count);
    end
  end

  ex_fwd_match #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .RD_W   (RD_W)
  ) u_fwd (
    .valid  (slot_valid),
    .wb_en  (wb_mem),
    .rd     (rd_mem),
    .result (result_mem),
    .head   (head),
    .fwd_rd (fwd_rd),
    .hit_c  (fwd_hit),
    .data_c (fwd_data)
  );

endmodule

// File: tb/tb_ex_result_buffer.sv
// Bench for ex_result_buffer: directed scenarios plus randomized traffic
// checked against a queue-based model of the buffer.
module tb_ex_result_buffer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic        in_zero = 1'b0, in_overflow = 1'b0, in_carry = 1'b0, in_negative = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        in_wb_en = 1'b0;
  logic        in_set_flags = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic        flag_z, flag_v, flag_c, flag_n;
  logic [1:0]  count;
  logic [4:0]  fwd_rd = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wb;
    logic        sf;
    logic [3:0]  fl;   // {n, c, v, z}
  } ent_t;

  ent_t       q[$];
  logic [3:0] mflags = '0;

  always #5 clk = ~clk;

  ex_result_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_zero(in_zero), .in_overflow(in_overflow), .in_carry(in_carry),
    .in_negative(in_negative), .in_rd(in_rd), .in_wb_en(in_wb_en),
    .in_set_flags(in_set_flags), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wb_en(out_wb_en),
    .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c), .flag_n(flag_n),
    .count(count), .fwd_rd(fwd_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  // Model: youngest buffered write-enabled match, r0 excluded
  function automatic void model_fwd(input logic [4:0] r, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (r != 5'd0)
      foreach (q[i]) if (q[i].wb && q[i].rd == r) begin hit = 1'b1; d = q[i].res; end
  endfunction

  // Advance the model with the current inputs, then move one clock edge
  task automatic tick();
    ent_t e;
    bit   full, do_push, do_pop;
    full    = (q.size() == DEPTH);
    do_push = in_valid && !full;
    do_pop  = out_ready && (q.size() != 0);
    if (flush) q.delete();
    else begin
      if (do_pop) begin
        e = q.pop_front();
        if (e.sf) mflags = e.fl;
      end
      if (do_push) begin
        e.res = in_result; e.rd = in_rd; e.wb = in_wb_en; e.sf = in_set_flags;
        e.fl  = {in_negative, in_carry, in_overflow, in_zero};
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] d,
                       input logic wb, input logic sf, input logic [3:0] fl);
    in_valid = v; in_result = r; in_rd = d; in_wb_en = wb; in_set_flags = sf;
    {in_negative, in_carry, in_overflow, in_zero} = fl;
  endtask

  task automatic test_reset();
    fwd_rd = 5'd3;
    #3;
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || fwd_hit !== 1'b0 ||
        {flag_n, flag_c, flag_v, flag_z} !== 4'h0) begin
      errors++;
      $display("FAIL reset: count=%0d out_valid=%b in_ready=%b fwd_hit=%b flags=%b, want 0 0 1 0 0000",
               count, out_valid, in_ready, fwd_hit, {flag_n, flag_c, flag_v, flag_z});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    q.delete(); mflags = '0;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(1, 32'd15, 5'd3, 1, 0, 4'h0);
    tick();
    drive(0, 0, 0, 0, 0, 4'h0);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd15 || out_rd !== 5'd3 || count !== 2'd1) begin
      errors++;
      $display("FAIL basic_out: valid=%b result=%0d rd=%0d count=%0d, want 1 15 3 1",
               out_valid, out_result, out_rd, count);
    end
    tick();
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: count=%0d valid=%b, want 0 0", count, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1, 32'hA, 5'd1, 1, 0, 4'h0); tick();
    drive(1, 32'hB, 5'd2, 1, 0, 4'h0); tick();
    checks++;
    if (count !== 2'd2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: count=%0d in_ready=%b, want 2 0", count, in_ready);
    end
    drive(1, 32'hC, 5'd3, 1, 0, 4'h0); tick();
    checks++;
    if (count !== 2'd2 || out_result !== 32'hA) begin
      errors++;
      $display("FAIL bp_refused: count=%0d head=%h, want 2 a", count, out_result);
    end
    drive(0, 0, 0, 0, 0, 4'h0);
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_result !== 32'hB || in_ready !== 1'b1 || count !== 2'd1) begin
      errors++;
      $display("FAIL bp_order: head=%h in_ready=%b count=%0d, want b 1 1", out_result, in_ready, count);
    end
    tick();
    checks++;
    if (count !== 2'd0) begin
      errors++;
      $display("FAIL bp_drain: count=%0d, want 0", count);
    end
  endtask

  task automatic test_flags();
    out_ready = 1'b1;
    drive(1, 32'hFFFF_FFFB, 5'd6, 1, 1, 4'b1000); tick();
    drive(0, 0, 0, 0, 0, 4'h0);
    checks++;
    if (flag_n !== 1'b0) begin
      errors++;
      $display("FAIL flags_before_pop: flag_n=%b, want 0", flag_n);
    end
    tick();
    checks++;
    if (flag_n !== 1'b1 || flag_z !== 1'b0 || flag_c !== 1'b0 || flag_v !== 1'b0) begin
      errors++;
      $display("FAIL flags_commit: nzcv=%b%b%b%b, want 1000", flag_n, flag_z, flag_c, flag_v);
    end
    drive(1, 32'd0, 5'd7, 1, 0, 4'b0001); tick();
    drive(0, 0, 0, 0, 0, 4'h0); tick();
    checks++;
    if (flag_z !== 1'b0 || flag_n !== 1'b1) begin
      errors++;
      $display("FAIL flags_nocommit: z=%b n=%b, want 0 1", flag_z, flag_n);
    end
  endtask

  task automatic test_forward();
    out_ready = 1'b0;
    drive(1, 32'h11, 5'd4, 1, 0, 4'h0); tick();
    drive(1, 32'h22, 5'd4, 1, 0, 4'h0); tick();
    drive(0, 0, 0, 0, 0, 4'h0);
    fwd_rd = 5'd4; #1;
    checks++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin
      errors++;
      $display("FAIL fwd_youngest: hit=%b data=%h, want 1 22", fwd_hit, fwd_data);
    end
    fwd_rd = 5'd5; #1;
    checks++;
    if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin
      errors++;
      $display("FAIL fwd_miss: hit=%b data=%h, want 0 0", fwd_hit, fwd_data);
    end
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    drive(1, 32'h33, 5'd0, 1, 0, 4'h0); tick();
    fwd_rd = 5'd0; #1;
    checks++;
    if (fwd_hit !== 1'b0) begin
      errors++;
      $display("FAIL fwd_r0: hit=%b, want 0", fwd_hit);
    end
    drive(1, 32'h77, 5'd7, 1, 0, 4'h0);
    fwd_rd = 5'd7; #1;
    checks++;
    if (fwd_hit !== 1'b0) begin
      errors++;
      $display("FAIL fwd_same_cycle: hit=%b, want 0", fwd_hit);
    end
    tick();
    drive(0, 0, 0, 0, 0, 4'h0);
    checks++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'h77) begin
      errors++;
      $display("FAIL fwd_next_cycle: hit=%b data=%h, want 1 77", fwd_hit, fwd_data);
    end
    out_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1, 32'h1, 5'd9, 1, 1, 4'b0001); tick();
    drive(1, 32'h2, 5'd10, 1, 1, 4'b0001); tick();
    flush = 1'b1; out_ready = 1'b1;
    drive(1, 32'h3, 5'd11, 1, 0, 4'h0); tick();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 4'h0);
    fwd_rd = 5'd11; #1;
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0 || fwd_hit !== 1'b0 || flag_n !== 1'b1 || flag_z !== 1'b0) begin
      errors++;
      $display("FAIL flush_full: count=%0d valid=%b hit=%b n=%b z=%b, want 0 0 0 1 0",
               count, out_valid, fwd_hit, flag_n, flag_z);
    end
    out_ready = 1'b0;
    drive(1, 32'h4, 5'd12, 1, 1, 4'b0001); tick();
    flush = 1'b1; out_ready = 1'b1;
    drive(1, 32'h5, 5'd13, 1, 0, 4'h0); tick();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 4'h0);
    fwd_rd = 5'd13; #1;
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0 || fwd_hit !== 1'b0 || flag_z !== 1'b0) begin
      errors++;
      $display("FAIL flush_partial: count=%0d valid=%b hit=%b z=%b, want 0 0 0 0",
               count, out_valid, fwd_hit, flag_z);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1, 32'h6, 5'd1, 1, 0, 4'h0); tick();
    drive(1, 32'h7, 5'd2, 1, 0, 4'h0); tick();
    drive(0, 0, 0, 0, 0, 4'h0);
    checks++;
    if (count !== 2'd2 || flag_n !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup: count=%0d n=%b, want 2 1", count, flag_n);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        {flag_n, flag_c, flag_v, flag_z} !== 4'h0) begin
      errors++;
      $display("FAIL areset_immediate: count=%0d valid=%b ready=%b flags=%b, want 0 0 1 0000",
               count, out_valid, in_ready, {flag_n, flag_c, flag_v, flag_z});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    q.delete(); mflags = '0;
  endtask

  task automatic test_random();
    logic        ehit;
    logic [31:0] edata;
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      fwd_rd    = 5'($urandom_range(0, 7));
      #1;
      model_fwd(fwd_rd, ehit, edata);
      checks++;
      if (count !== 2'(q.size()) || out_valid !== (q.size() != 0) || in_ready !== (q.size() < DEPTH)) begin
        errors++;
        $display("FAIL rand_state[%0d]: count=%0d valid=%b ready=%b, want count=%0d",
                 n, count, out_valid, in_ready, q.size());
      end
      checks++;
      if (q.size() != 0 && (out_result !== q[0].res || out_rd !== q[0].rd || out_wb_en !== q[0].wb)) begin
        errors++;
        $display("FAIL rand_head[%0d]: result=%h rd=%0d wb=%b, want %h %0d %b",
                 n, out_result, out_rd, out_wb_en, q[0].res, q[0].rd, q[0].wb);
      end
      checks++;
      if ({flag_n, flag_c, flag_v, flag_z} !== mflags) begin
        errors++;
        $display("FAIL rand_flags[%0d]: ncvz=%b, want %b", n, {flag_n, flag_c, flag_v, flag_z}, mflags);
      end
      checks++;
      if (fwd_hit !== ehit || fwd_data !== edata) begin
        errors++;
        $display("FAIL rand_fwd[%0d]: rd=%0d hit=%b data=%h, want %b %h", n, fwd_rd, fwd_hit, fwd_data, ehit, edata);
      end
      tick();
    end
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 4'h0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flags();
    test_forward();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
